// File: rtl/nco_phase_gen.sv
// -----------------------------------------------------------------------------
// nco_phase_gen
//
// Numerically controlled phase generator feeding the quarter-wave sin/cos LUT.
// A programmable divider produces a one-cycle sample strobe. On each strobe
// the phase accumulator advances by the active frequency tuning word (FTW), and
// the top PHASE_WIDTH bits plus a phase offset are presented as the LUT phase.
// FTW updates are double-buffered and swapped in only when the accumulator
// wraps, so frequency changes never cut a waveform cycle short.
//
// Ports
//   i_clk                  clock
//   i_rst                  synchronous reset, active-high
//   i_run                  level: 1 = generate, 0 = stop at the next wrap
//   i_div                  tick period minus one
//   i_ftw / i_ftw_valid    FTW offer; taken when o_ftw_ready is high
//   o_ftw_ready            pending FTW buffer is empty
//   i_phase_ofs            phase offset, added modulo 2^PHASE_WIDTH
//   o_en                   one-cycle sample strobe (LUT i_en)
//   o_phase                phase word (LUT i_phase), held between strobes
//   o_cycle_start          strobe-qualified first tick of a waveform cycle
//   o_cycle_start_aligned  o_cycle_start delayed LUT_LATENCY strobes
//   o_active               generator is not idle
// -----------------------------------------------------------------------------
module nco_phase_gen #(
    parameter int ACC_WIDTH   = 24,
    parameter int PHASE_WIDTH = 13,
    parameter int DIV_WIDTH   = 8,
    parameter int LUT_LATENCY = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_run,
    input  logic [DIV_WIDTH-1:0]   i_div,
    input  logic [ACC_WIDTH-1:0]   i_ftw,
    input  logic                   i_ftw_valid,
    output logic                   o_ftw_ready,
    input  logic [PHASE_WIDTH-1:0] i_phase_ofs,
    output logic                   o_en,
    output logic [PHASE_WIDTH-1:0] o_phase,
    output logic                   o_cycle_start,
    output logic                   o_cycle_start_aligned,
    output logic                   o_active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state, next_state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   ftw_active;
    logic [ACC_WIDTH-1:0]   ftw_pending;
    logic                   pend_valid;
    logic [DIV_WIDTH-1:0]   cnt;
    logic [DIV_WIDTH-1:0]   div_cur;
    logic                   first_tick;   // next tick is the first after start
    logic                   carry_prev;   // previous tick's add wrapped
    logic                   drain_end;    // terminal drain tick is on o_en now
    logic [LUT_LATENCY-1:0] align_sr;

    logic [ACC_WIDTH:0]     sum;
    logic                   carry;
    logic                   start;
    logic                   counting;
    logic                   tick;
    logic                   swap;

    // NOTE: every signal driven here gets a default first so no latch is
    // inferred when a branch does not assign it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (i_run) next_state = RUN;
            RUN:   if (!i_run) next_state = DRAIN;
            DRAIN: begin
                // The terminal tick already zeroed acc, so it always stops;
                // otherwise a zero FTW can never wrap and stops at once.
                if (drain_end)              next_state = IDLE;
                else if (i_run)             next_state = RUN;
                else if (ftw_active == '0)  next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        sum      = {1'b0, acc} + {1'b0, ftw_active};
        carry    = sum[ACC_WIDTH];
        start    = (state == IDLE) && i_run;
        // The divider runs only while staying active, which also blocks a
        // stray tick in the cycle the generator drops back to IDLE.
        counting = (state != IDLE) && (next_state != IDLE);
        tick     = counting && (cnt == div_cur);
        // A zero FTW never wraps, so its replacement is taken on any tick.
        swap     = pend_valid &&
                   ((state == IDLE) || (tick && (carry || ftw_active == '0)));
    end

    assign o_ftw_ready           = !pend_valid;
    assign o_active              = (state != IDLE);
    assign o_cycle_start_aligned = align_sr[LUT_LATENCY-1];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            acc           <= '0;
            ftw_active    <= '0;
            ftw_pending   <= '0;
            pend_valid    <= 1'b0;
            cnt           <= '0;
            div_cur       <= '0;
            first_tick    <= 1'b0;
            carry_prev    <= 1'b0;
            drain_end     <= 1'b0;
            o_en          <= 1'b0;
            o_phase       <= '0;
            o_cycle_start <= 1'b0;
            align_sr      <= '0;
        end else begin
            state         <= next_state;
            o_en          <= tick;
            o_cycle_start <= tick && (first_tick || carry_prev);
            drain_end     <= tick && carry && (next_state == DRAIN);

            // Divider: a new period is loaded only at a wrap.
            if (start) begin
                cnt     <= '0;
                div_cur <= i_div;
            end else if (counting) begin
                if (cnt == div_cur) begin
                    cnt     <= '0;
                    div_cur <= i_div;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Accumulator and phase output.
            if (start) begin
                acc        <= '0;
                first_tick <= 1'b1;
                carry_prev <= 1'b0;
            end else if (tick) begin
                acc        <= (carry && next_state == DRAIN) ? '0 : sum[ACC_WIDTH-1:0];
                o_phase    <= acc[ACC_WIDTH-1 -: PHASE_WIDTH] + i_phase_ofs;
                first_tick <= 1'b0;
                carry_prev <= carry;
            end else if (state == DRAIN && next_state == IDLE) begin
                acc <= '0;
            end

            // Cycle-start delay line, advanced once per presented sample.
            if (o_en) begin
                align_sr[0] <= o_cycle_start;
                for (int i = 1; i < LUT_LATENCY; i++) begin
                    align_sr[i] <= align_sr[i-1];
                end
            end

            // FTW double buffer; ready gates capture, so capture and swap
            // never coincide.
            if (swap) begin
                ftw_active <= ftw_pending;
                pend_valid <= 1'b0;
            end else if (i_ftw_valid && !pend_valid) begin
                ftw_pending <= i_ftw;
                pend_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_nco_phase_gen
//
// Self-checking bench for nco_phase_gen. A tick-level reference model tracks
// the accumulator, FTW double buffer and cycle-start history with plain
// integer arithmetic; each test task drives one scenario and compares.
// -----------------------------------------------------------------------------
module tb_nco_phase_gen;

    localparam int AW  = 24;
    localparam int PW  = 13;
    localparam int DW  = 8;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [DW-1:0] div;
    logic [AW-1:0] ftw;
    logic          ftw_valid;
    logic          ftw_ready;
    logic [PW-1:0] ofs;
    logic          en;
    logic [PW-1:0] phase;
    logic          cs;
    logic          csa;
    logic          active;

    int errors = 0;
    int checks = 0;

    // Reference model state (tick granularity).
    longint m_acc;
    longint m_ftw;
    longint m_pend;
    bit     m_pend_v;
    bit     m_first;
    bit     m_pc;
    bit     cs_hist[$];
    time    last_t;

    always #5 clk = ~clk;

    nco_phase_gen #(
        .ACC_WIDTH  (AW),
        .PHASE_WIDTH(PW),
        .DIV_WIDTH  (DW),
        .LUT_LATENCY(LAT)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_run                (run),
        .i_div                (div),
        .i_ftw                (ftw),
        .i_ftw_valid          (ftw_valid),
        .o_ftw_ready          (ftw_ready),
        .i_phase_ofs          (ofs),
        .o_en                 (en),
        .o_phase              (phase),
        .o_cycle_start        (cs),
        .o_cycle_start_aligned(csa),
        .o_active             (active)
    );

    function automatic bit exp_aligned();
        // Value visible from the end of the last strobe up to the next one.
        return (cs_hist.size() >= LAT) ? cs_hist[cs_hist.size() - LAT] : 1'b0;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_ftw = 0; m_pend = 0; m_pend_v = 0; m_first = 0; m_pc = 0;
        cs_hist.delete();
    endtask

    task automatic model_tick(input bit draining, output logic [PW-1:0] ep,
                              output bit ecs, output bit eal, output bit fin);
        longint s;
        bit     c;
        ep  = PW'((m_acc >> (AW - PW)) + longint'(ofs));
        ecs = m_first | m_pc;
        eal = exp_aligned();
        cs_hist.push_back(ecs);
        s   = m_acc + m_ftw;
        c   = (s >= (64'd1 << AW));
        fin = draining && c;
        m_acc = fin ? 0 : (s & ((64'd1 << AW) - 1));
        if ((c || m_ftw == 0) && m_pend_v) begin
            m_ftw = m_pend; m_pend_v = 0;
        end
        m_pc = c; m_first = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; ftw_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic start_run();
        run = 1'b1; m_acc = 0; m_first = 1; m_pc = 0; last_t = 0;
    endtask

    // FTW handshake while idle: ready must drop for exactly one cycle.
    task automatic load_idle(input logic [AW-1:0] v, input string tag);
        ftw = v; ftw_valid = 1'b1;
        @(negedge clk);
        ftw_valid = 1'b0;
        checks++;
        if (ftw_ready !== 1'b0) begin
            errors++; $display("FAIL %s ready_after_capture: got %b want 0", tag, ftw_ready);
        end
        @(negedge clk);
        checks++;
        if (ftw_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_after_move: got %b want 1", tag, ftw_ready);
        end
        m_ftw = v;
    endtask

    // Bounded wait for the next strobe; quiet cycles must hold the outputs.
    task automatic wait_en(input string tag, output bit ok);
        ok = 1'b0;
        for (int b = 0; b < 600; b++) begin
            @(negedge clk);
            if (en === 1'b1) begin ok = 1'b1; break; end
            checks++;
            if (cs !== 1'b0 || csa !== exp_aligned()) begin
                errors++;
                $display("FAIL %s hold: cs=%b csa=%b want cs=0 csa=%b", tag, cs, csa, exp_aligned());
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s timeout: no o_en within 600 cycles", tag);
        end
    endtask

    // Observe n strobes against the model; optionally drop i_run or offer an
    // FTW right after a given strobe (offers need gap >= 2).
    task automatic observe_ticks(input int n, input int gap_exp, input int stop_at,
                                 input int offer_at, input logic [AW-1:0] offer_val,
                                 input string tag);
        bit draining = (run == 1'b0);
        for (int k = 1; k <= n; k++) begin
            bit ok, ecs, eal, fin;
            logic [PW-1:0] ep;
            wait_en(tag, ok);
            if (!ok) return;
            model_tick(draining, ep, ecs, eal, fin);
            checks += 3;
            if (phase !== ep) begin
                errors++; $display("FAIL %s phase tick%0d: got %0d want %0d", tag, k, phase, ep);
            end
            if (cs !== ecs) begin
                errors++; $display("FAIL %s cycle_start tick%0d: got %b want %b", tag, k, cs, ecs);
            end
            if (csa !== eal) begin
                errors++; $display("FAIL %s aligned tick%0d: got %b want %b", tag, k, csa, eal);
            end
            if (last_t != 0) begin
                checks++;
                if (($time - last_t) / 10 != gap_exp) begin
                    errors++;
                    $display("FAIL %s gap tick%0d: got %0d want %0d", tag, k, ($time - last_t) / 10, gap_exp);
                end
            end
            last_t = $time;
            if (k == stop_at) begin run = 1'b0; draining = 1'b1; end
            if (k == offer_at) begin
                ftw = offer_val; ftw_valid = 1'b1;
                @(negedge clk);
                ftw_valid = 1'b0;
                checks++;
                if (ftw_ready !== 1'b0) begin
                    errors++; $display("FAIL %s ready_pending: got %b want 0", tag, ftw_ready);
                end
                m_pend = offer_val; m_pend_v = 1'b1;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (en !== 1'b0 || phase !== '0 || cs !== 1'b0 || csa !== 1'b0 ||
            active !== 1'b0 || ftw_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s outputs: en=%b phase=%0d cs=%b csa=%b active=%b ready=%b want 0,0,0,0,0,1",
                     tag, en, phase, cs, csa, active, ftw_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_idle_outputs("reset");
    endtask

    task automatic test_basic();
        do_reset();
        div = 8'd3; ofs = '0;
        load_idle(24'h100000, "basic");
        start_run();
        observe_ticks(18, 4, 0, 0, '0, "basic");
    endtask

    task automatic test_midrun_ftw();
        do_reset();
        div = 8'd3; ofs = '0;
        load_idle(24'h100000, "mid");
        start_run();
        observe_ticks(15, 4, 0, 5, 24'h200000, "mid");
        checks++;
        if (ftw_ready !== 1'b0) begin
            errors++; $display("FAIL mid ready_tick15: got %b want 0", ftw_ready);
        end
        observe_ticks(1, 4, 0, 0, '0, "mid");
        checks++;
        if (ftw_ready !== 1'b1) begin
            errors++; $display("FAIL mid ready_tick16: got %b want 1", ftw_ready);
        end
        observe_ticks(12, 4, 0, 0, '0, "mid");
    endtask

    task automatic test_drain();
        do_reset();
        div = 8'd3; ofs = '0;
        load_idle(24'h100000, "drain");
        start_run();
        observe_ticks(16, 4, 8, 0, '0, "drain");
        checks++;
        if (active !== 1'b1 || phase !== 13'd7680) begin
            errors++; $display("FAIL drain last_tick: active=%b phase=%0d want 1,7680", active, phase);
        end
        @(negedge clk);
        checks++;
        if (active !== 1'b0) begin
            errors++; $display("FAIL drain active_fall: got %b want 0", active);
        end
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (en !== 1'b0 || csa !== exp_aligned()) begin
                errors++; $display("FAIL drain idle_quiet: en=%b csa=%b want 0,%b", en, csa, exp_aligned());
            end
        end
        start_run();
        observe_ticks(3, 4, 0, 0, '0, "restart");
    endtask

    task automatic test_offset_div0();
        do_reset();
        div = 8'd0; ofs = 13'd4096;
        load_idle(24'h100000, "ofs");
        start_run();
        observe_ticks(20, 1, 0, 0, '0, "ofs");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            logic [AW-1:0] f0, f1;
            do_reset();
            f0  = {8'($urandom_range(8, 255)), 16'($urandom)};
            f1  = {8'($urandom_range(8, 255)), 16'($urandom)};
            div = 8'($urandom_range(1, 4));
            ofs = 13'($urandom);
            load_idle(f0, "rand");
            start_run();
            observe_ticks(40, int'(div) + 1, 0, 12, f1, "rand");
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        div = 8'd1; ofs = '0;
        load_idle(24'h100000, "rstdrain");
        start_run();
        observe_ticks(3, 2, 2, 2, 24'h300000, "rstdrain");
        checks++;
        if (ftw_ready !== 1'b0 || active !== 1'b1) begin
            errors++; $display("FAIL rstdrain pre: ready=%b active=%b want 0,1", ftw_ready, active);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rstdrain");
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        start_run();
        observe_ticks(5, 2, 0, 0, '0, "zeroftw");
        run = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (active !== 1'b0) begin
            errors++; $display("FAIL zeroftw drain_exit: active=%b want 0", active);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; div = '0; ftw = '0; ftw_valid = 1'b0; ofs = '0;
        model_reset();
        test_reset();
        test_basic();
        test_midrun_ftw();
        test_drain();
        test_offset_div0();
        test_random();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nco_phase_gen.md
Name: nco_phase_gen

Overview:
- Numerically controlled phase generator. It sits directly upstream of the quarter-wave sine/cosine LUT stage.
- Produces the LUT phase word and the LUT clock-enable strobe from a divided sample tick.
- Frequency-tuning-word (FTW) updates are double-buffered and take effect only at an accumulator wrap, so waveform frequency changes are phase-continuous and glitch-free.
- Provides a clean start/stop at zero phase and a cycle-start marker re-aligned to the LUT output latency.

Parameters:
ACC_WIDTH, 24, phase accumulator width (must be >= PHASE_WIDTH)
PHASE_WIDTH, 13, output phase width (LUT I_WIDTH)
DIV_WIDTH, 8, sample-tick divider width
LUT_LATENCY, 3, downstream LUT latency in enabled cycles

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_run  in  1  level; 1 = generate, 0 = stop at next wrap
i_div  in  DIV_WIDTH  tick period minus one (o_en every i_div+1 clocks)
i_ftw  in  ACC_WIDTH  frequency tuning word
i_ftw_valid  in  1  FTW offer
o_ftw_ready  out  1  pending FTW buffer empty
i_phase_ofs  in  PHASE_WIDTH  phase offset, added mod 2^PHASE_WIDTH
o_en  out  1  one-cycle sample strobe (drives LUT i_en)
o_phase  out  PHASE_WIDTH  phase word (drives LUT i_phase)
o_cycle_start  out  1  pulse with o_en on first tick of each waveform cycle
o_cycle_start_aligned  out  1  cycle_start delayed LUT_LATENCY ticks
o_active  out  1  state != IDLE

Behaviour:
- Reset (i_rst=1 at clock edge, overrides all):
  - State IDLE; acc, ftw_active and divider count = 0; pending buffer empty.
  - o_ftw_ready=1; o_en=0; o_phase=0; o_cycle_start=0; alignment shift register cleared (o_cycle_start_aligned=0); o_active=0.
  - Reset mid-run discards any pending FTW.
- FTW handshake:
  - Transfer occurs when i_ftw_valid & o_ftw_ready. i_ftw is captured into the pending buffer, and o_ftw_ready goes 0 the next cycle.
  - In IDLE, pending moves to ftw_active on the following clock.
  - In RUN/DRAIN, pending moves to ftw_active on the tick whose acc+ftw_active carries out of ACC_WIDTH. The new value is used from the next tick.
  - o_ftw_ready returns to 1 the cycle after the move.
  - If ftw_active=0 while running, a pending FTW moves on the next tick, because no wrap would ever occur.
- Divider:
  - Counter cleared on IDLE->RUN.
  - Counts 0..i_div; at i_div it wraps to 0 and the next cycle has o_en=1.
  - i_div=0 gives o_en on every cycle while active.
  - i_div changes take effect at the next counter wrap.
- Tick (o_en=1 cycle):
  - o_phase = acc_prev[ACC_WIDTH-1 -: PHASE_WIDTH] + i_phase_ofs (mod 2^PHASE_WIDTH), with i_phase_ofs sampled at that edge.
  - acc <= acc_prev + ftw_active (mod 2^ACC_WIDTH).
  - o_phase holds between ticks; o_en is never high in IDLE.
  - The first tick after start presents phase = i_phase_ofs (acc=0).
- o_cycle_start:
  - 1 on the first tick after start.
  - 1 on every tick following a tick whose add carried.
  - 0 otherwise.
- Alignment:
  - A shift register of depth LUT_LATENCY shifts o_cycle_start on every o_en.
  - o_cycle_start_aligned = last stage, held as a level between ticks.
  - Not cleared in IDLE.
- State machine:
  - IDLE -> RUN when i_run=1.
  - RUN -> DRAIN when i_run=0.
  - DRAIN -> RUN when i_run=1 (no restart; acc and divider retained).
  - DRAIN -> IDLE on the tick whose add carries; that tick still outputs normally, and acc <= 0 instead of the sum.
  - DRAIN -> IDLE immediately if ftw_active=0.
  - IDLE -> RUN requires i_run=1 in IDLE; a run held high throughout does not re-enter DRAIN.
- Simultaneous events:
  - Capture and move in the same cycle is not possible (ready gates capture).
  - Wrap plus i_run fall: the FTW swap still happens.
  - A DRAIN terminal tick with a pending FTW swaps it, so the next start uses the new FTW.

Test Plan:
- Reset, then i_ftw=0x100000 handshake in IDLE, i_div=3, i_run=1 -> o_en every 4 clocks; o_phase sequence 0,512,1024,…,7680,0; o_cycle_start on ticks 1 and 17; o_ftw_ready low for exactly 1 cycle after capture.
- Mid-run FTW 0x200000 offered at tick 5 -> accepted, o_ftw_ready low until the wrap tick 16; phase steps become 1024 from tick 17; no discontinuity before that.
- i_run dropped at tick 8 with FTW 0x100000 -> ticks continue to tick 16 (phase 7680); o_active falls the next cycle; acc=0; restart yields phase 0 first.
- i_phase_ofs=4096, FTW 0x100000, i_div=0 -> o_en every clock, phase 4096,4608,…; wraps 8191->0 modulo correctly.
- o_cycle_start_aligned asserts exactly LUT_LATENCY=3 ticks after o_cycle_start, and holds until the next tick.
- i_rst asserted mid-DRAIN with a pending FTW -> all outputs 0 next cycle, o_ftw_ready=1, pending lost (ftw_active=0 after restart with no new handshake: no phase advance).
